// File: rtl/cp0_reg.sv
// Coprocessor-0 system-control register file: Count/Compare timer,
// Status/Cause/EPC exception bookkeeping and the mfc0 read port.
module cp0_reg #(
    parameter logic [31:0] PRID_VALUE   = 32'h0048_0102,
    parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] exc_type_i,
    input  logic [31:0] exc_inst_addr_i,
    input  logic        exc_in_delayslot_i,
    output logic [31:0] rdata_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_STATUS  = 5'd12;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;
    localparam logic [4:0] ADDR_EPC     = 5'd14;
    localparam logic [4:0] ADDR_PRID    = 5'd15;
    localparam logic [4:0] ADDR_CONFIG  = 5'd16;

    localparam logic [31:0] STATUS_RESET = 32'h1000_0000;

    logic [31:0] count_q,   count_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] status_q,  status_d;
    logic [31:0] cause_q,   cause_d;
    logic [31:0] epc_q,     epc_d;
    logic        timer_int_q, timer_int_d;

    logic        exc_take;
    logic        exc_eret;
    logic [4:0]  exc_code;

    // Decode the committed exception type into an ExcCode or eret.
    always_comb begin
        exc_take = 1'b1;
        exc_eret = 1'b0;
        exc_code = 5'd0;
        case (exc_type_i)
            32'h0000_0001: exc_code = 5'd0;
            32'h0000_0008: exc_code = 5'd8;
            32'h0000_0009: exc_code = 5'd9;
            32'h0000_000a: exc_code = 5'd10;
            32'h0000_000c: exc_code = 5'd12;
            32'h0000_000d: exc_code = 5'd13;
            32'h0000_000e: begin
                exc_take = 1'b0;
                exc_eret = 1'b1;
            end
            default: exc_take = 1'b0;
        endcase
    end

    // Next-state: mtc0 effects first, then exception effects override the fields they touch.
    always_comb begin
        count_d     = count_q + 32'd1;
        compare_d   = compare_q;
        status_d    = status_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        timer_int_d = timer_int_q;

        if ((compare_q != 32'd0) && (count_q == compare_q)) begin
            timer_int_d = 1'b1;
        end

        cause_d[15:10] = int_i;

        if (we_i) begin
            case (waddr_i)
                ADDR_COUNT:   count_d = wdata_i;
                ADDR_COMPARE: begin
                    compare_d   = wdata_i;
                    timer_int_d = 1'b0;
                end
                ADDR_STATUS:  status_d = wdata_i;
                ADDR_CAUSE:   begin
                    cause_d[9:8]   = wdata_i[9:8];
                    cause_d[23:22] = wdata_i[23:22];
                end
                ADDR_EPC:     epc_d = wdata_i;
                default:      ;
            endcase
        end

        if (exc_take) begin
            if (!status_q[1]) begin
                epc_d       = exc_in_delayslot_i ? (exc_inst_addr_i - 32'd4) : exc_inst_addr_i;
                cause_d[31] = exc_in_delayslot_i;
            end
            status_d[1]   = 1'b1;
            cause_d[6:2]  = exc_code;
        end else if (exc_eret) begin
            status_d[1] = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= 32'd0;
            compare_q   <= 32'd0;
            status_q    <= STATUS_RESET;
            cause_q     <= 32'd0;
            epc_q       <= 32'd0;
            timer_int_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            compare_q   <= compare_d;
            status_q    <= status_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            timer_int_q <= timer_int_d;
        end
    end

    // Combinational mfc0 read port over current state; no write bypass.
    always_comb begin
        rdata_o = 32'd0;
        case (raddr_i)
            ADDR_COUNT:   rdata_o = count_q;
            ADDR_COMPARE: rdata_o = compare_q;
            ADDR_STATUS:  rdata_o = status_q;
            ADDR_CAUSE:   rdata_o = cause_q;
            ADDR_EPC:     rdata_o = epc_q;
            ADDR_PRID:    rdata_o = PRID_VALUE;
            ADDR_CONFIG:  rdata_o = CONFIG_VALUE;
            default:      rdata_o = 32'd0;
        endcase
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign config_o    = CONFIG_VALUE;
    assign prid_o      = PRID_VALUE;
    assign timer_int_o = timer_int_q;

endmodule

// File: tb/tb_cp0_reg.sv
// Bench for cp0_reg: reference model updated every edge, compared every cycle,
// plus directed literal checks.
module tb_cp0_reg;

    localparam logic [31:0] PRID   = 32'h0048_0102;
    localparam logic [31:0] CONFIG = 32'h0000_8000;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [5:0]  int_i;
    logic [31:0] exc_type_i;
    logic [31:0] exc_inst_addr_i;
    logic        exc_in_delayslot_i;
    logic [31:0] rdata_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
    logic        timer_int_o;

    int n_total = 0;
    int n_pass  = 0;

    cp0_reg #(.PRID_VALUE(PRID), .CONFIG_VALUE(CONFIG)) dut (
        .clk                (clk),
        .rst                (rst),
        .we_i               (we_i),
        .waddr_i            (waddr_i),
        .wdata_i            (wdata_i),
        .raddr_i            (raddr_i),
        .int_i              (int_i),
        .exc_type_i         (exc_type_i),
        .exc_inst_addr_i    (exc_inst_addr_i),
        .exc_in_delayslot_i (exc_in_delayslot_i),
        .rdata_o            (rdata_o),
        .count_o            (count_o),
        .compare_o          (compare_o),
        .status_o           (status_o),
        .cause_o            (cause_o),
        .epc_o              (epc_o),
        .config_o           (config_o),
        .prid_o             (prid_o),
        .timer_int_o        (timer_int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
    logic        m_timer;
    bit          m_valid = 0;

    localparam logic [31:0] CAUSE_WMASK = 32'h00C0_0300;

    // -1: ignored, -2: eret, otherwise the ExcCode
    function automatic int code_of(input logic [31:0] t);
        case (t)
            32'h01: return 0;
            32'h08: return 8;
            32'h09: return 9;
            32'h0a: return 10;
            32'h0c: return 12;
            32'h0d: return 13;
            32'h0e: return -2;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd9:  return m_count;
            5'd11: return m_compare;
            5'd12: return m_status;
            5'd13: return m_cause;
            5'd14: return m_epc;
            5'd15: return PRID;
            5'd16: return CONFIG;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [31:0] n_count, n_compare, n_status, n_cause, n_epc;
        logic        n_timer;
        int          c;
        if (rst) begin
            m_count = 0; m_compare = 0; m_status = 32'h1000_0000;
            m_cause = 0; m_epc = 0; m_timer = 0; m_valid = 1;
        end else begin
            n_count   = m_count + 1;
            n_compare = m_compare;
            n_status  = m_status;
            n_epc     = m_epc;
            n_timer   = m_timer | ((m_compare != 0) && (m_count == m_compare));
            n_cause   = (m_cause & ~32'h0000_FC00) | ({26'd0, int_i} << 10);
            if (we_i && waddr_i == 9)  n_count = wdata_i;
            if (we_i && waddr_i == 11) begin n_compare = wdata_i; n_timer = 0; end
            if (we_i && waddr_i == 12) n_status = wdata_i;
            if (we_i && waddr_i == 13) n_cause = (n_cause & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK);
            if (we_i && waddr_i == 14) n_epc = wdata_i;
            c = code_of(exc_type_i);
            if (c >= 0) begin
                if (m_status[1] == 1'b0) begin
                    n_epc = exc_in_delayslot_i ? exc_inst_addr_i - 4 : exc_inst_addr_i;
                    n_cause[31] = exc_in_delayslot_i;
                end
                n_status = n_status | 32'h2;
                n_cause  = (n_cause & ~32'h7C) | (32'(c) << 2);
            end else if (c == -2) begin
                n_status = n_status & ~32'h2;
            end
            m_count = n_count; m_compare = n_compare; m_status = n_status;
            m_cause = n_cause; m_epc = n_epc; m_timer = n_timer;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("count",   count_o,   m_count);
            chk("compare", compare_o, m_compare);
            chk("status",  status_o,  m_status);
            chk("cause",   cause_o,   m_cause);
            chk("epc",     epc_o,     m_epc);
            chk("timer",   {31'd0, timer_int_o}, {31'd0, m_timer});
            chk("config",  config_o,  CONFIG);
            chk("prid",    prid_o,    PRID);
            chk("rdata",   rdata_o,   m_read(raddr_i));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we_i = 0; waddr_i = 0; wdata_i = 0;
        exc_type_i = 0; exc_inst_addr_i = 0; exc_in_delayslot_i = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i = 1; waddr_i = a; wdata_i = d;
        tick();
        we_i = 0;
    endtask

    task automatic exc(input logic [31:0] t, input logic [31:0] a, input logic ds);
        exc_type_i = t; exc_inst_addr_i = a; exc_in_delayslot_i = ds;
        tick();
        exc_type_i = 0; exc_inst_addr_i = 0; exc_in_delayslot_i = 0;
    endtask

    initial begin
        rst = 1; raddr_i = 5'd15; int_i = 0;
        idle_inputs();
        tick(); tick();
        rst = 0;

        // 1: reset values and free-running count
        repeat (3) tick();
        chk("t1 count", count_o, 32'd3);
        chk("t1 model count", m_count, 32'd3);
        chk("t1 status", status_o, 32'h1000_0000);
        chk("t1 cause", cause_o, 32'd0);
        chk("t1 epc", epc_o, 32'd0);
        chk("t1 timer", {31'd0, timer_int_o}, 32'd0);
        chk("t1 rdata prid", rdata_o, PRID);
        raddr_i = 5'd16; #1 chk("t1 rdata config", rdata_o, CONFIG);
        raddr_i = 5'd3;  #1 chk("t1 rdata unknown", rdata_o, 32'd0);

        // 2: count wrap
        raddr_i = 5'd9;
        mtc0(5'd9, 32'hFFFF_FFFE);
        chk("t2 count load", count_o, 32'hFFFF_FFFE);
        tick(); chk("t2 count max", count_o, 32'hFFFF_FFFF);
        tick(); chk("t2 count wrap", count_o, 32'd0);

        // 3: timer match, hold, clear
        mtc0(5'd11, 32'd20);
        mtc0(5'd9, 32'd10);
        chk("t3 count", count_o, 32'd10);
        repeat (10) tick();
        chk("t3 count at match", count_o, 32'd20);
        chk("t3 timer before", {31'd0, timer_int_o}, 32'd0);
        tick();
        chk("t3 timer rise", {31'd0, timer_int_o}, 32'd1);
        repeat (3) tick();
        chk("t3 timer hold", {31'd0, timer_int_o}, 32'd1);
        mtc0(5'd11, 32'd100);
        chk("t3 timer clear", {31'd0, timer_int_o}, 32'd0);
        chk("t3 compare", compare_o, 32'd100);

        // 4: syscall in delay slot, then nested overflow
        raddr_i = 5'd14;
        exc(32'h08, 32'h0000_1010, 1'b1);
        chk("t4 epc", epc_o, 32'h0000_100C);
        chk("t4 cause", cause_o, 32'h8000_0020);
        chk("t4 status", status_o, 32'h1000_0002);
        chk("t4 model epc", m_epc, 32'h0000_100C);
        exc(32'h0c, 32'h0000_2000, 1'b0);
        chk("t4 epc nested", epc_o, 32'h0000_100C);
        chk("t4 cause nested", cause_o, 32'h8000_0030);

        // 5: eret, then exception colliding with mtc0 Status
        raddr_i = 5'd12;
        exc(32'h0e, 32'h0, 1'b0);
        chk("t5 eret status", status_o, 32'h1000_0000);
        we_i = 1; waddr_i = 5'd12; wdata_i = 32'h0;
        exc(32'h0a, 32'h0000_3000, 1'b0);
        we_i = 0;
        chk("t5 status collide", status_o, 32'h0000_0002);
        chk("t5 epc collide", epc_o, 32'h0000_3000);
        chk("t5 cause collide", cause_o, 32'h0000_0028);

        // ignored code and writes to read-only/unknown addresses
        exc(32'h05, 32'h0000_4000, 1'b1);
        chk("ignored exc epc", epc_o, 32'h0000_3000);
        mtc0(5'd15, 32'hDEAD_BEEF);
        mtc0(5'd16, 32'hDEAD_BEEF);
        mtc0(5'd2,  32'hDEAD_BEEF);
        chk("ro prid", prid_o, PRID);

        // reset mid-operation with write and exception active
        rst = 1; we_i = 1; waddr_i = 5'd9; wdata_i = 32'd5;
        exc_type_i = 32'h08; exc_inst_addr_i = 32'h100;
        tick();
        rst = 0; idle_inputs();
        chk("rst count", count_o, 32'd0);
        chk("rst status", status_o, 32'h1000_0000);
        chk("rst epc", epc_o, 32'd0);
        chk("rst cause", cause_o, 32'd0);

        // 6: Cause write mask with interrupt sampling
        raddr_i = 5'd13;
        int_i = 6'b101010;
        mtc0(5'd13, 32'hFFFF_FFFF);
        chk("t6 cause", cause_o, 32'h00C0_AB00);
        int_i = 6'b000000;
        tick();
        chk("t6 cause int clear", cause_o, 32'h00C0_0300);

        // sweep the read port
        for (int a = 0; a < 32; a++) begin
            raddr_i = 5'(a);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
